// File: rtl/fsm_stim_driver.sv
// -----------------------------------------------------------------------------
// fsm_stim_driver
//
// Transmit-side companion for the serial Mealy sequence FSM (states AC/BD/E/F).
// Accepts parallel stimulus words on a valid/ready handshake, shifts each word
// MSB-first onto x (one bit per clock), samples the FSM's Mealy output z on
// every bit and returns the collected response word. A cycle-accurate shadow
// of the sequence FSM predicts z and flags any disagreement.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high reset
//   in_valid     stimulus word offered
//   in_ready     driver can accept a word (IDLE only)
//   in_data      stimulus word, MSB sent first
//   x            serial stimulus to the sequence FSM
//   z            Mealy output returned by the sequence FSM
//   out_valid    one-cycle pulse: response word ready
//   out_data     sampled z bits, first sampled bit in MSB
//   out_err      qualifies out_valid: some bit of this word mismatched
//   err_sticky   set on any mismatch, cleared only by reset
//   shadow_state shadow FSM state (AC=000, BD=001, E=010, F=011), for debug
// -----------------------------------------------------------------------------
module fsm_stim_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             x,
    input  logic             z,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             err_sticky,
    output logic [2:0]       shadow_state
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Shadow encodings are plain codes rather than an enum so that the
    // illegal values 100-111 remain representable and recoverable.
    localparam logic [2:0] S_AC = 3'b000;
    localparam logic [2:0] S_BD = 3'b001;
    localparam logic [2:0] S_E  = 3'b010;
    localparam logic [2:0] S_F  = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ctrl_t;

    ctrl_t            ctrl_q, ctrl_next;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] resp_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             mismatch_q;
    logic [2:0]       shadow_q, shadow_next;
    logic             z_pred;
    logic             bit_mismatch;
    logic             last_bit;

    assign shadow_state = shadow_q;
    assign last_bit     = (bit_cnt_q == LAST_BIT);
    assign bit_mismatch = (z != z_pred);

    // ------------------------------------------------------------------
    // Control next-state and the two combinational outputs.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned; otherwise synthesis infers a latch.
        ctrl_next = ctrl_q;
        in_ready  = 1'b0;
        x         = 1'b0;
        unique case (ctrl_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) ctrl_next = SHIFT;
            end
            SHIFT: begin
                x = shift_q[WIDTH-1];
                if (last_bit) ctrl_next = DONE;
            end
            DONE: begin
                ctrl_next = IDLE;
            end
            default: begin
                ctrl_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow of the sequence FSM: next state and predicted Mealy output
    // for the x actually being driven this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        shadow_next = S_AC;
        z_pred      = 1'b0;
        case (shadow_q)
            S_AC: begin
                shadow_next = x ? S_BD : S_E;
                z_pred      = x;
            end
            S_BD: begin
                shadow_next = x ? S_BD : S_F;
            end
            S_E: begin
                shadow_next = x ? S_F : S_AC;
                z_pred      = x;
            end
            S_F: begin
                shadow_next = x ? S_AC : S_BD;
            end
            default: begin
                shadow_next = S_AC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, datapath and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= IDLE;
            shadow_q   <= S_AC;
            shift_q    <= '0;
            resp_q     <= '0;
            bit_cnt_q  <= '0;
            mismatch_q <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of its peers, independent of statement order.
            ctrl_q    <= ctrl_next;
            shadow_q  <= shadow_next;
            out_valid <= 1'b0;

            unique case (ctrl_q)
                IDLE: begin
                    if (in_valid) begin
                        shift_q    <= in_data;
                        bit_cnt_q  <= '0;
                        mismatch_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    shift_q   <= shift_q << 1;
                    resp_q    <= {resp_q[WIDTH-2:0], z};
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    if (bit_mismatch) begin
                        mismatch_q <= 1'b1;
                        err_sticky <= 1'b1;
                    end
                    // The result registers are loaded on the edge that enters
                    // DONE (folding in the final bit directly) so that
                    // out_data/out_err are valid in the same cycle as
                    // out_valid, and then hold until the next word completes.
                    if (last_bit) begin
                        out_valid <= 1'b1;
                        out_data  <= {resp_q[WIDTH-2:0], z};
                        out_err   <= mismatch_q | bit_mismatch;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_stim_driver.sv
// -----------------------------------------------------------------------------
// tb_fsm_stim_driver
//
// Self-checking bench for fsm_stim_driver. A behavioural sequence FSM sits on
// x/z (with an optional z inversion), expected response words go into a
// scoreboard queue when a word is offered and are compared when out_valid
// pulses. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fsm_stim_driver;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             x;
    logic             z;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             err_sticky;
    logic [2:0]       shadow_state;

    fsm_stim_driver #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .x            (x),
        .z            (z),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_err      (out_err),
        .err_sticky   (err_sticky),
        .shadow_state (shadow_state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural sequence FSM on x/z ----------------
    logic [2:0] peer_q, peer_next;
    logic       peer_z;
    logic       flip_z;

    always @(posedge clk or posedge reset) begin
        if (reset) peer_q <= 3'b000;
        else       peer_q <= peer_next;
    end

    always_comb begin
        peer_next = 3'b000;
        peer_z    = 1'b0;
        case (peer_q)
            3'b000: begin peer_next = x ? 3'b001 : 3'b010; peer_z = x; end
            3'b001: begin peer_next = x ? 3'b001 : 3'b011; end
            3'b010: begin peer_next = x ? 3'b011 : 3'b000; peer_z = x; end
            3'b011: begin peer_next = x ? 3'b000 : 3'b001; end
            default: begin peer_next = 3'b000; end
        endcase
    end

    assign z = peer_z ^ flip_z;

    // ---------------- bookkeeping ----------------
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   out_pulses = 0;

    // Shadow state expected in cycles 0..9 of a word of all ones from reset.
    logic [2:0] w1_shadow [0:9] = '{3'd0, 3'd2, 3'd3, 3'd0, 3'd1,
                                    3'd1, 3'd1, 3'd1, 3'd1, 3'd1};

    always @(posedge clk) begin
        if (out_valid) out_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the current output word against the scoreboard head.
    task automatic check_word(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_unexpected_word"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"}, 32'(out_data), 32'(e.data));
            check({tag, "_err"}, 32'(out_err), 32'(e.err));
        end
    endtask

    // Wait (bounded) for the next out_valid pulse, then score it.
    task automatic wait_word(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (seen) check_word(tag);
        else      check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        flip_z   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] word;
        int               base;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        flip_z   = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- reset values ----------------
        check("rst_in_ready",   32'(in_ready),     32'd1);
        check("rst_x",          32'(x),            32'd0);
        check("rst_out_valid",  32'(out_valid),    32'd0);
        check("rst_out_data",   32'(out_data),     32'd0);
        check("rst_out_err",    32'(out_err),      32'd0);
        check("rst_err_sticky", 32'(err_sticky),   32'd0);
        check("rst_shadow",     32'(shadow_state), 32'd0);

        // ---------------- first word 8'hFF, then 8'h55 back-to-back ----------
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        sb.push_back('{data: 8'hA0, err: 1'b0});
        #1 check("w1_shadow_c0", 32'(shadow_state), 32'(w1_shadow[0]));
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                in_data = 8'h55;   // held during busy; accepted once IDLE
                sb.push_back('{data: 8'h10, err: 1'b0});
            end
            check($sformatf("w1_x_c%0d", c),        32'(x),            32'(c <= 8));
            check($sformatf("w1_in_ready_c%0d", c), 32'(in_ready),     32'd0);
            check($sformatf("w1_shadow_c%0d", c),   32'(shadow_state), 32'(w1_shadow[c]));
            check($sformatf("w1_out_valid_c%0d", c), 32'(out_valid),   32'(c == 9));
            if (c == 9) check_word("w1");
        end
        @(negedge clk);   // cycle 10: IDLE again, 8'h55 accepted at its end
        check("b2b_in_ready_c10", 32'(in_ready),     32'd1);
        check("b2b_out_valid_c10", 32'(out_valid),   32'd0);
        check("b2b_shadow_c10",   32'(shadow_state), 32'd3);
        word = 8'h55;
        for (int c = 11; c <= 19; c++) begin
            @(negedge clk);
            if (c == 11) in_valid = 1'b0;
            if (c <= 18) check($sformatf("b2b_x_c%0d", c), 32'(x), 32'(word[18-c]));
            if (c == 12) check("b2b_out_data_hold", 32'(out_data), 32'hA0);
            check($sformatf("b2b_out_valid_c%0d", c), 32'(out_valid), 32'(c == 19));
            if (c == 19) check_word("b2b");
        end

        // ---------------- mismatch on bit 3 ----------------
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        sb.push_back('{data: 8'h80, err: 1'b1});
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
            flip_z = (c == 3);
            check($sformatf("mm_err_sticky_c%0d", c), 32'(err_sticky), 32'(c >= 4));
            if (c == 9) begin
                check("mm_out_valid", 32'(out_valid), 32'd1);
                check_word("mm");
            end
        end
        @(negedge clk);   // IDLE: offer a clean all-zero word
        in_valid = 1'b1;
        in_data  = 8'h00;
        sb.push_back('{data: 8'h00, err: 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        wait_word("clean", 15);
        check("clean_err_sticky", 32'(err_sticky), 32'd1);

        // ---------------- busy ignore ----------------
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        sb.push_back('{data: 8'hA0, err: 1'b0});
        base = out_pulses;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            in_valid = (c <= 7) ? c[0] : (c <= 9);
            in_data  = 8'h3C ^ 8'(c);
            check($sformatf("busy_in_ready_c%0d", c), 32'(in_ready), 32'(c == 10));
            if (c == 10) in_valid = 1'b0;
            if (c == 9) check_word("busy");
        end
        repeat (15) @(negedge clk);
        check("busy_pulses", 32'(out_pulses - base), 32'd1);
        check("busy_out_data_hold", 32'(out_data), 32'hA0);

        // ---------------- reset during bit 4 ----------------
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        base = out_pulses;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
        end
        check("mr_x_before", 32'(x), 32'd1);
        reset = 1'b1;
        #1;
        check("mr_x",         32'(x),            32'd0);
        check("mr_in_ready",  32'(in_ready),     32'd1);
        check("mr_shadow",    32'(shadow_state), 32'd0);
        check("mr_out_data",  32'(out_data),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("mr_no_out_valid", 32'(out_pulses - base), 32'd0);
        check("mr_sb_empty",     32'(sb.size()),         32'd0);

        // ---------------- illegal shadow code ----------------
        // Forced in bit 2 of an all-ones word, where the sequence FSM is in F
        // with x=1: its next state is AC and Z=0, matching illegal recovery.
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        sb.push_back('{data: 8'hA0, err: 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        force dut.shadow_q = 3'b111;
        #1 check("ill_forced", 32'(shadow_state), 32'd7);
        #2 release dut.shadow_q;
        @(negedge clk);
        check("ill_next_ac", 32'(shadow_state), 32'd0);
        wait_word("ill", 15);
        check("ill_err_sticky", 32'(err_sticky), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
